proc_sequencer: RTL

- Multi-cycle control FSM that sequences the 32-bit-IR processor datapath through fetch, decode, execute, memory access and next-PC for each instruction.
- Sits between program memory, the ALU/register-file datapath and the data-memory/external-I/O port, and drives their strobes.
- Resolves conditional jumps from datapath flags, flags illegal opcodes and halts on HALT.

---
 rtl/proc_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/proc_sequencer.sv
// Multi-cycle instruction sequencer: fetch, load IR, execute, memory handshake, next-PC.
// Strobes are registered and set on the edge entering their state; sendreg's write strobe follows dmem_ack.
module proc_sequencer #(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            sys_rst,
  input  logic            start,
  output logic [PC_W-1:0] pmem_addr,
  output logic            pmem_rd,
  input  logic [31:0]     pmem_data,
  output logic [31:0]     ir,
  output logic            exec_en,
  output logic            rf_we,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [1:0]      dmem_sel,
  input  logic            dmem_ack,
  input  logic [3:0]      flags,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD_IR, S_EXEC, S_MEM, S_NEXT, S_HALT
  } state_t;

  localparam logic [4:0] OP_ALU_MAX  = 5'b01011;
  localparam logic [4:0] OP_STOREREG = 5'b01101;
  localparam logic [4:0] OP_STOREDIN = 5'b01110;
  localparam logic [4:0] OP_SENDDOUT = 5'b01111;
  localparam logic [4:0] OP_SENDREG  = 5'b10001;
  localparam logic [4:0] OP_JUMP     = 5'b10010;
  localparam logic [4:0] OP_JC       = 5'b10011;
  localparam logic [4:0] OP_JNC      = 5'b10100;
  localparam logic [4:0] OP_JS       = 5'b10101;
  localparam logic [4:0] OP_JNS      = 5'b10110;
  localparam logic [4:0] OP_JZ       = 5'b10111;
  localparam logic [4:0] OP_JNZ      = 5'b11000;
  localparam logic [4:0] OP_JO       = 5'b11001;
  localparam logic [4:0] OP_JNO      = 5'b11010;
  localparam logic [4:0] OP_HALT     = 5'b11011;

  function automatic logic is_alu(input logic [4:0] op);
    return op <= OP_ALU_MAX;
  endfunction

  function automatic logic is_mem(input logic [4:0] op);
    return (op == OP_STOREREG) || (op == OP_STOREDIN) ||
           (op == OP_SENDDOUT) || (op == OP_SENDREG);
  endfunction

  function automatic logic is_jump(input logic [4:0] op);
    return (op >= OP_JUMP) && (op <= OP_JNO);
  endfunction

  function automatic logic jump_cond(input logic [4:0] op, input logic [3:0] f);
    case (op)
      OP_JUMP: return 1'b1;
      OP_JC:   return f[3];
      OP_JNC:  return ~f[3];
      OP_JS:   return f[2];
      OP_JNS:  return ~f[2];
      OP_JZ:   return f[1];
      OP_JNZ:  return ~f[1];
      OP_JO:   return f[0];
      OP_JNO:  return ~f[0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] mem_sel(input logic [4:0] op);
    case (op)
      OP_STOREREG: return 2'b00;
      OP_STOREDIN: return 2'b01;
      OP_SENDDOUT: return 2'b10;
      default:     return 2'b11;
    endcase
  endfunction

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_ir;
  logic            r_pmem_rd;
  logic            r_exec_en;
  logic            r_rf_we;
  logic            r_dmem_req;
  logic            r_dmem_we;
  logic [1:0]      r_dmem_sel;
  logic            r_busy;
  logic            r_halted;
  logic            r_illegal;
  logic            r_taken;

  logic [4:0]      w_op;
  logic [4:0]      w_load_op;
  logic            w_load_legal;
  logic            w_sendreg_ack;

  assign w_op         = r_ir[31:27];
  assign w_load_op    = pmem_data[31:27];
  assign w_load_legal = is_alu(w_load_op) || is_mem(w_load_op) ||
                        is_jump(w_load_op) || (w_load_op == OP_HALT);

  // The register-file write for sendreg lands in the very cycle the port acknowledges.
  assign w_sendreg_ack = (r_state == S_MEM) && (r_dmem_sel == 2'b11) && dmem_ack;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_pmem_rd  <= 1'b0;
      r_exec_en  <= 1'b0;
      r_rf_we    <= 1'b0;
      r_dmem_req <= 1'b0;
      r_dmem_we  <= 1'b0;
      r_dmem_sel <= 2'b00;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_illegal  <= 1'b0;
      r_taken    <= 1'b0;
    end else begin
      r_pmem_rd <= 1'b0;
      r_exec_en <= 1'b0;
      r_rf_we   <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_FETCH;
            r_pc      <= '0;
            r_pmem_rd <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_FETCH: r_state <= S_LOAD_IR;
        S_LOAD_IR: begin
          // Decode the incoming word so the EXEC-cycle strobes leave straight from flops.
          r_ir    <= pmem_data;
          r_state <= S_EXEC;
          if (is_alu(w_load_op)) begin
            r_exec_en <= 1'b1;
            r_rf_we   <= 1'b1;
          end else if (!w_load_legal) begin
            r_illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          r_taken <= 1'b0;
          if (is_mem(w_op)) begin
            r_state    <= S_MEM;
            r_dmem_req <= 1'b1;
            r_dmem_we  <= (w_op == OP_STOREREG) || (w_op == OP_STOREDIN);
            r_dmem_sel <= mem_sel(w_op);
          end else if (w_op == OP_HALT) begin
            r_state  <= S_HALT;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else begin
            r_state <= S_NEXT;
            r_taken <= is_jump(w_op) && jump_cond(w_op, flags);
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_state    <= S_NEXT;
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_dmem_sel <= 2'b00;
          end
        end
        S_NEXT: begin
          r_pc      <= r_taken ? r_ir[PC_W-1:0] : r_pc + {{(PC_W-1){1'b0}}, 1'b1};
          r_taken   <= 1'b0;
          r_state   <= S_FETCH;
          r_pmem_rd <= 1'b1;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pmem_addr = r_pc;
  assign pmem_rd   = r_pmem_rd;
  assign ir        = r_ir;
  assign exec_en   = r_exec_en;
  assign rf_we     = r_rf_we | w_sendreg_ack;
  assign dmem_req  = r_dmem_req;
  assign dmem_we   = r_dmem_we;
  assign dmem_sel  = r_dmem_sel;
  assign pc        = r_pc;
  assign busy      = r_busy;
  assign halted    = r_halted;
  assign illegal   = r_illegal;

endmodule
